// File: rtl/alu_unit_if.sv
// alu_unit_if
//   Bundles the ALU operand/operation inputs, the combinational result and the
//   registered status flags into one bus between the CPU datapath and alu_unit.
//   master : datapath side (drives alu_op, a, b, flag_en; observes result/flags)
//   slave  : ALU side (observes operands; drives result/flags)
//   Signals: alu_op[OP_WIDTH], a[WIDTH], b[WIDTH], flag_en,
//            result[WIDTH], zero, neg, carry, ovf
interface alu_unit_if #(
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 2
);
  logic [OP_WIDTH-1:0] alu_op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                flag_en;
  logic [WIDTH-1:0]    result;
  logic                zero;
  logic                neg;
  logic                carry;
  logic                ovf;

  modport master (
    output alu_op, a, b, flag_en,
    input  result, zero, neg, carry, ovf
  );

  modport slave (
    input  alu_op, a, b, flag_en,
    output result, zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit
//   Two-operand integer ALU for the single-cycle CPU datapath. The result is
//   purely combinational (ADD, SUB, AND, OR); status flags from the most recent
//   enabled operation are held in registers for branch/compare logic.
//   Ports:
//     clk  : rising-edge clock shared with the register file
//     rst  : synchronous active-high reset, clears only the flag registers
//     bus  : alu_unit_if slave modport
//            alu_op, a, b, flag_en in; result (comb), zero/neg/carry/ovf (reg) out
module alu_unit #(
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  alu_unit_if.slave  bus
);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);

  // Signed overflow from operand/result sign bits. For SUB the effective
  // second operand is ~b, so the "same sign in" test flips to "different sign".
  function automatic logic ovf_calc(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    if (sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else     return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  logic                is_sub_p0;
  logic [WIDTH-1:0]    b_eff_p0;
  logic [WIDTH:0]      sum_p0;
  logic [WIDTH-1:0]    res_p0;
  logic                nxt_zero_p0;
  logic                nxt_neg_p0;
  logic                nxt_carry_p0;
  logic                nxt_ovf_p0;

  logic                zero_p1;
  logic                neg_p1;
  logic                carry_p1;
  logic                ovf_p1;

  // ---- Stage p0: combinational operate and next-flag generation ----
  // One shared WIDTH+1-bit adder; SUB is a + ~b + 1 so bit WIDTH is no-borrow.
  assign is_sub_p0 = (bus.alu_op == OP_SUB);
  assign b_eff_p0  = is_sub_p0 ? ~bus.b : bus.b;
  assign sum_p0    = {1'b0, bus.a} + {1'b0, b_eff_p0} + {{WIDTH{1'b0}}, is_sub_p0};

  always_comb begin
    res_p0       = '0;
    nxt_carry_p0 = 1'b0;
    nxt_ovf_p0   = 1'b0;
    case (bus.alu_op)
      OP_ADD, OP_SUB: begin
        res_p0       = sum_p0[WIDTH-1:0];
        nxt_carry_p0 = sum_p0[WIDTH];
        nxt_ovf_p0   = ovf_calc(is_sub_p0, bus.a[WIDTH-1], bus.b[WIDTH-1],
                                sum_p0[WIDTH-1]);
      end
      OP_AND:  res_p0 = bus.a & bus.b;
      OP_OR:   res_p0 = bus.a | bus.b;
      // Unused codes (only reachable when OP_WIDTH > 2) yield 0, so z=1, n=0.
      default: res_p0 = '0;
    endcase
  end

  assign nxt_zero_p0 = (res_p0 == '0);
  assign nxt_neg_p0  = res_p0[WIDTH-1];

  assign bus.result = res_p0;

  // ---- Stage p1: flag registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_p1  <= 1'b0;
      neg_p1   <= 1'b0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
    end else if (bus.flag_en) begin
      zero_p1  <= nxt_zero_p0;
      neg_p1   <= nxt_neg_p0;
      carry_p1 <= nxt_carry_p0;
      ovf_p1   <= nxt_ovf_p0;
    end
  end

  assign bus.zero  = zero_p1;
  assign bus.neg   = neg_p1;
  assign bus.carry = carry_p1;
  assign bus.ovf   = ovf_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors with literal expectations,
// then randomized operations checked every cycle against an arithmetic model.
module tb_alu_unit;
  localparam int W  = 16;
  localparam int OW = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_unit_if #(.WIDTH(W), .OP_WIDTH(OW)) bus ();

  alu_unit #(.WIDTH(W), .OP_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } model_t;

  // Reference model from the arithmetic definitions using wide integers.
  function automatic model_t model(input logic [OW-1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    model_t m;
    longint ua, ub, sa, sb, full, sres, modv;
    modv = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - modv : ua;
    sb = b[W-1] ? ub - modv : ub;
    m = '0;
    sres = 0;
    full = 0;
    case (op)
      2'd0: begin
        full = ua + ub;
        m.c  = (ua + ub) >= modv;
        sres = sa + sb;
        m.v  = (sres >= modv / 2) || (sres < -(modv / 2));
      end
      2'd1: begin
        full = ua - ub + modv;
        m.c  = ua >= ub;
        sres = sa - sb;
        m.v  = (sres >= modv / 2) || (sres < -(modv / 2));
      end
      2'd2: full = ua & ub;
      default: full = ua | ub;
    endcase
    m.r = W'(full % modv);
    m.z = (m.r == '0);
    m.n = m.r[W-1];
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected flag state, tracked from the reset/enable rules.
  logic [3:0] exp_flags;
  logic       flags_known;
  initial flags_known = 1'b0;

  always @(posedge clk) begin
    model_t m;
    m = model(bus.alu_op, bus.a, bus.b);
    if (rst) begin
      exp_flags   = 4'b0000;
      flags_known = 1'b1;
    end else if (bus.flag_en && flags_known) begin
      exp_flags = {m.z, m.n, m.c, m.v};
    end
  end

  // Compare process: result against model every cycle, flags once defined.
  always @(negedge clk) begin
    model_t m;
    m = model(bus.alu_op, bus.a, bus.b);
    check("cmp_result", 32'(bus.result), 32'(m.r));
    if (flags_known)
      check("cmp_flags", {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, {28'd0, exp_flags});
  end

  task automatic set_in(input logic [OW-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic en);
    bus.alu_op  = op;
    bus.a       = a;
    bus.b       = b;
    bus.flag_en = en;
  endtask

  // Called just after a rising edge: apply, check result mid-cycle, check flags after the edge.
  task automatic directed(input string name, input logic [OW-1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    set_in(op, a, b, 1'b1);
    @(negedge clk); #1;
    check({name, "_result"}, 32'(bus.result), 32'(exp_r));
    @(posedge clk); #1;
    check({name, "_flags"}, {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, {28'd0, exp_f});
  endtask

  initial begin
    model_t pm;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_in(2'd0, '0, '0, 1'b0);

    // Pin the model with hand-computed values.
    pm = model(2'd0, 16'h7FFF, 16'h0001);
    check("model_add_ovf", {11'd0, pm}, {11'd0, 16'h8000, 4'b0101});
    pm = model(2'd1, 16'h0003, 16'h0005);
    check("model_sub_borrow", {11'd0, pm}, {11'd0, 16'hFFFE, 4'b0100});
    pm = model(2'd1, 16'h8000, 16'h0001);
    check("model_sub_ovf", {11'd0, pm}, {11'd0, 16'h7FFF, 4'b0011});

    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 32'd0);
    rst = 1'b0;

    //       name         op     a         b         result    {z,n,c,v}
    directed("add_ovf",  2'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    directed("add_wrap", 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    directed("sub_brw",  2'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100);
    directed("sub_eq",   2'd1, 16'h1234, 16'h1234, 16'h0000, 4'b1010);
    directed("sub_sovf", 2'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
    directed("and",      2'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
    directed("or",       2'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0100);

    // Flag hold, then reset priority over flag_en.
    directed("hold_load", 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    set_in(2'd0, 16'h0001, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hold_result", 32'(bus.result), 32'h0002);
      @(posedge clk); #1;
      check("hold_flags", {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 32'b1010);
    end
    rst = 1'b1;
    bus.flag_en = 1'b1;
    @(posedge clk); #1;
    check("rst_flags", {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 32'd0);
    check("rst_result", 32'(bus.result), 32'h0002);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_load", {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 32'b0000);

    // Randomized sweep with flag_en=1.
    for (int i = 0; i < 10000; i++) begin
      set_in(OW'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'b1);
      @(posedge clk); #1;
    end
    // Random enable and occasional reset.
    for (int i = 0; i < 1000; i++) begin
      set_in(OW'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
